// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game-logic FSM driving the 15x15 grid memory port,
// with a circular body queue and raster-probe food placement.
module snake_ctrl #(
   parameter int MAX_LEN = 32
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       step_i,
   input  logic [1:0] dir_i,
   output logic [4:0] mem_x_o,
   output logic [4:0] mem_y_o,
   output logic       mem_re_o,
   output logic [1:0] mem_wdata_o,
   input  logic [1:0] mem_rdata_i,
   output logic       busy_o,
   output logic       game_over_o,
   output logic [7:0] score_o,
   output logic [6:0] length_o
);
   localparam int PW = $clog2(MAX_LEN);
   localparam logic [1:0] EMPTY = 2'b00, FOOD = 2'b01, SNAKE = 2'b10;
   typedef enum logic [2:0] {IDLE, CHECK, ETAIL, WHEAD, FSEEK, FWR, DEAD} state_t;

   state_t state_q, state_d;
   logic [4:0] qx_q [MAX_LEN];
   logic [4:0] qy_q [MAX_LEN];
   logic [PW-1:0] hd_q, tl_q;
   logic [6:0] len_q;
   logic [7:0] score_q;
   logic [1:0] dir_q, ndir;
   logic [4:0] nx_q, ny_q, px_q, py_q, rx_q, ry_q, ex_q, ey_q;
   logic [4:0] hx, hy, tx, ty, sx, sy;
   logic grow_q, ers_q, wall, at_tail, full;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [9:0] rstep(input logic [4:0] x, input logic [4:0] y);
      return (x != 5'd15) ? {x + 5'd1, y} : {5'd1, (y == 5'd15) ? 5'd1 : y + 5'd1};
   endfunction

   assign hx = qx_q[hd_q];
   assign hy = qy_q[hd_q];
   assign tx = qx_q[tl_q];
   assign ty = qy_q[tl_q];
   // a reversal request keeps the current heading
   assign ndir = ((dir_i ^ dir_q) == 2'b10) ? dir_q : dir_i;
   assign sx = (ndir == 2'd0) ? hx + 5'd1 : (ndir == 2'd2) ? hx - 5'd1 : hx;
   assign sy = (ndir == 2'd1) ? hy + 5'd1 : (ndir == 2'd3) ? hy - 5'd1 : hy;
   assign wall = sx == 5'd0 || sx == 5'd16 || sy == 5'd0 || sy == 5'd16;
   assign at_tail = nx_q == tx && ny_q == ty;
   assign full = len_q == 7'(MAX_LEN);
   assign score_o = score_q;
   assign length_o = len_q;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (step_i) state_d = wall ? DEAD : CHECK;
         CHECK:   state_d = (mem_rdata_i == SNAKE && !at_tail) ? DEAD :
                            (mem_rdata_i == FOOD) ? WHEAD : ETAIL;
         ETAIL:   state_d = WHEAD;
         WHEAD:   state_d = grow_q ? FSEEK : IDLE;
         FSEEK:   state_d = (!ers_q && mem_rdata_i == EMPTY) ? FWR : FSEEK;
         FWR:     state_d = IDLE;
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      mem_x_o = hx;
      mem_y_o = hy;
      mem_re_o = 1'b1;
      mem_wdata_o = EMPTY;
      busy_o = state_q != IDLE && state_q != DEAD;
      game_over_o = state_q == DEAD;
      case (state_q)
         CHECK: begin
            mem_x_o = nx_q;
            mem_y_o = ny_q;
         end
         ETAIL: begin
            mem_x_o = tx;
            mem_y_o = ty;
            mem_re_o = 1'b0;
         end
         WHEAD: begin
            mem_x_o = nx_q;
            mem_y_o = ny_q;
            mem_re_o = 1'b0;
            mem_wdata_o = SNAKE;
         end
         // a full snake that ate spends its first probe cycle erasing the old tail
         FSEEK: begin
            mem_x_o = ers_q ? ex_q : px_q;
            mem_y_o = ers_q ? ey_q : py_q;
            mem_re_o = !ers_q;
         end
         FWR: begin
            mem_x_o = px_q;
            mem_y_o = py_q;
            mem_re_o = 1'b0;
            mem_wdata_o = FOOD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         rx_q <= 5'd1;
         ry_q <= 5'd1;
      end else {rx_q, ry_q} <= rstep(rx_q, ry_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            qx_q[i] <= '0;
            qy_q[i] <= '0;
         end
         qx_q[0] <= 5'd1;
         qy_q[0] <= 5'd1;
         qx_q[1] <= 5'd2;
         qy_q[1] <= 5'd1;
         qx_q[2] <= 5'd3;
         qy_q[2] <= 5'd1;
         tl_q <= '0;
         hd_q <= PW'(2);
         len_q <= 7'd3;
         score_q <= '0;
         dir_q <= '0;
         nx_q <= '0;
         ny_q <= '0;
         px_q <= 5'd1;
         py_q <= 5'd1;
         ex_q <= '0;
         ey_q <= '0;
         grow_q <= 1'b0;
         ers_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (step_i) begin
               nx_q <= sx;
               ny_q <= sy;
               dir_q <= ndir;
            end
            CHECK: grow_q <= mem_rdata_i == FOOD;
            ETAIL: tl_q <= inc(tl_q);
            WHEAD: begin
               hd_q <= inc(hd_q);
               qx_q[inc(hd_q)] <= nx_q;
               qy_q[inc(hd_q)] <= ny_q;
               if (grow_q) begin
                  score_q <= (score_q == 8'hff) ? score_q : score_q + 8'd1;
                  {px_q, py_q} <= {rx_q, ry_q};
                  ers_q <= full;
                  if (full) begin
                     tl_q <= inc(tl_q);
                     ex_q <= tx;
                     ey_q <= ty;
                  end else len_q <= len_q + 7'd1;
               end
            end
            FSEEK: if (ers_q) ers_q <= 1'b0;
                   else if (mem_rdata_i != EMPTY) {px_q, py_q} <= rstep(px_q, py_q);
            default: ;
         endcase
      end
   end
endmodule
